bet_counter_sequencer: RTL

//   Command-driven controller for a cascaded balanced-ternary (BET) load/up/down counter.

---
 rtl/bet_counter_sequencer_if.sv | 30 +++
 rtl/bet_counter_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bet_counter_sequencer_if.sv
// Command channel into the BET counter sequencer: op, start, target, direction.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready; a command transfers on a clock edge where both are high.
// Ports (master = host side, slave = sequencer side):
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer idle and able to take a command
//   cmd_op     master->slave  trit 01 = LOAD, 10 = RUN
//   cmd_start  master->slave  value to load, MS trit first
//   cmd_target master->slave  RUN stop value, MS trit first
//   cmd_dir    master->slave  RUN direction trit 10 = up, 01 = down, 11 = hold
interface bet_counter_sequencer_if #(
  parameter int TRITS = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [2*TRITS-1:0]   cmd_start;
  logic [2*TRITS-1:0]   cmd_target;
  logic [1:0]           cmd_dir;

  modport master (
    output cmd_valid, cmd_op, cmd_start, cmd_target, cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start, cmd_target, cmd_dir,
    output cmd_ready
  );
endinterface

// File: rtl/bet_counter_sequencer.sv
// Sequences LOAD / RUN-TO-TARGET commands onto a cascaded balanced-ternary counter.
// Latency: accept to done is 3 cycles for LOAD, 4 + steps cycles for RUN; invalid command errs after 2.
// Backpressure: cmd_ready only in IDLE; command inputs are ignored while busy.
// Ports:
//   clock, reset   rising-edge clock shared with the counter; synchronous active-high reset
//   cmd            command channel (slave modport)
//   cnt_load/cnt_data/cnt_dir  drive counter LoadEn, Data, Dir
//   cnt_value      counter output, updates on the edge after its inputs are applied
//   busy, done, err, steps     status; done/err are one-cycle pulses, steps held until next accept
module bet_counter_sequencer #(
  parameter int TRITS     = 2,
  parameter int MAX_STEPS = 9,
  parameter int STEP_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  bet_counter_sequencer_if.slave cmd,
  output logic                cnt_load,
  output logic [2*TRITS-1:0]  cnt_data,
  output logic [1:0]          cnt_dir,
  input  logic [2*TRITS-1:0]  cnt_value,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [STEP_W-1:0]   steps
);

  localparam int W = 2 * TRITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [1:0] TRIT_ZERO = 2'b11;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  logic [2:0]   state;
  logic [1:0]   op_q;
  logic [W-1:0] start_q;
  logic [W-1:0] target_q;
  logic [1:0]   dir_q;

  logic bad_cmd;
  logic at_target;
  logic timeout;

  // Any 2'b00 trit in the captured command, or the illegal op, is rejected
  // before the counter is touched.
  always_comb begin
    bad_cmd = (op_q == 2'b00) || (op_q == OP_ILLEGAL) || (dir_q == 2'b00);
    for (int i = 0; i < TRITS; i++) begin
      if (start_q[2*i +: 2] == 2'b00)  bad_cmd = 1'b1;
      if (target_q[2*i +: 2] == 2'b00) bad_cmd = 1'b1;
    end
  end

  assign at_target = (cnt_value == target_q);
  assign timeout   = (steps == STEP_W'(MAX_STEPS));

  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR);
  assign cnt_load      = (state == S_LOAD);

  // Direction is combinational on cnt_value so the counter is held on the
  // very edge it would otherwise step past the target (or past the timeout).
  always_comb begin
    cnt_dir = TRIT_ZERO;
    if (state == S_RUN && !at_target && !timeout) begin
      cnt_dir = dir_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      steps    <= '0;
      cnt_data <= {TRITS{TRIT_ZERO}};
      op_q     <= TRIT_ZERO;
      start_q  <= {TRITS{TRIT_ZERO}};
      target_q <= {TRITS{TRIT_ZERO}};
      dir_q    <= TRIT_ZERO;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q     <= cmd.cmd_op;
            start_q  <= cmd.cmd_start;
            target_q <= cmd.cmd_target;
            dir_q    <= cmd.cmd_dir;
            steps    <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad_cmd) begin
            state <= S_ERR;
          end else begin
            // cnt_data keeps this value after the load pulse ends.
            cnt_data <= start_q;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= (op_q == OP_RUN) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (at_target) begin
            state <= S_DONE;
          end else if (timeout) begin
            state <= S_ERR;
          end else begin
            steps <= steps + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
